// File: rtl/link_event_arbiter.sv
// link_event_arbiter: round-robin grant of two framed-event link FIFOs onto one router stub input.
// Optional frame-abort timeout is compiled in when LINK_TIMEOUT_EN is defined.
module link_event_arbiter #(
    parameter logic [7:0] TIMEOUT = 8'd80
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en_proc,
    input  logic [35:0] link0_data,
    input  logic        link0_empty,
    output logic        link0_rd_en,
    input  logic [35:0] link1_data,
    input  logic        link1_empty,
    output logic        link1_rd_en,
    input  logic        router_rd_en,
    output logic        start,
    output logic [35:0] stub_out,
    output logic        stub_valid,
    output logic [1:0]  grant,
    output logic [2:0]  evt_cnt,
    output logic [7:0]  last_bx,
    output logic [7:0]  drop_cnt,
    output logic        timeout_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, XFER = 2'd2} state_t;

    state_t      state, state_n;
    logic [1:0]  grant_n;
    logic        start_n;
    logic        prio, prio_n;
    logic [2:0]  evt_cnt_n;
    logic [7:0]  last_bx_n, drop_cnt_n;
    logic        hdr0, hdr1, drop0, drop1;
    logic        stub_empty, xfer, trailer_xfer;
    logic [8:0]  drop_sum;

    function automatic logic is_header(input logic [35:0] w);
        return (w[35:33] == 3'b111) && (w[24:0] == 25'h1ffffff);
    endfunction

    function automatic logic is_trailer(input logic [35:0] w);
        return (w[35:33] == 3'b111) && (w[24:0] == 25'h0000000);
    endfunction

    assign hdr0  = ~link0_empty & is_header(link0_data);
    assign hdr1  = ~link1_empty & is_header(link1_data);
    // Non-header heads are flushed only while idle, enabled and out of reset.
    assign drop0 = (state == IDLE) & en_proc & reset & ~link0_empty & ~is_header(link0_data);
    assign drop1 = (state == IDLE) & en_proc & reset & ~link1_empty & ~is_header(link1_data);

    always_comb begin
        stub_out   = 36'd0;
        stub_empty = 1'b1;
        if (grant[0]) begin
            stub_out   = link0_data;
            stub_empty = link0_empty;
        end else if (grant[1]) begin
            stub_out   = link1_data;
            stub_empty = link1_empty;
        end
    end

    assign stub_valid   = (state == XFER) & en_proc & ~stub_empty;
    assign xfer         = stub_valid & router_rd_en;
    assign trailer_xfer = xfer & is_trailer(stub_out);
    assign link0_rd_en  = (grant[0] & xfer) | drop0;
    assign link1_rd_en  = (grant[1] & xfer) | drop1;
    assign drop_sum     = {1'b0, drop_cnt} + {8'd0, drop0} + {8'd0, drop1};

`ifdef LINK_TIMEOUT_EN
    logic [7:0] idle_cnt, idle_cnt_n;
    logic       timeout_q, timeout_n;
    assign timeout_err = timeout_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_err    = 1'b0;
`endif

    always_comb begin
        state_n    = state;
        grant_n    = grant;
        start_n    = 1'b0;
        prio_n     = prio;
        evt_cnt_n  = evt_cnt;
        last_bx_n  = last_bx;
        drop_cnt_n = drop_sum[8] ? 8'hff : drop_sum[7:0];
`ifdef LINK_TIMEOUT_EN
        idle_cnt_n = idle_cnt;
        timeout_n  = timeout_q;
`endif
        case (state)
            IDLE: begin
                if (hdr0 & hdr1)
                    grant_n = prio ? 2'b10 : 2'b01;
                else if (hdr0)
                    grant_n = 2'b01;
                else if (hdr1)
                    grant_n = 2'b10;
                if (hdr0 | hdr1) begin
                    state_n = START;
                    start_n = 1'b1;
                end
            end
            START: begin
                state_n = XFER;
`ifdef LINK_TIMEOUT_EN
                idle_cnt_n = 8'd0;
`endif
            end
            XFER: begin
                if (trailer_xfer) begin
                    last_bx_n = stub_out[32:25];
                    evt_cnt_n = evt_cnt + 3'd1;
                    prio_n    = grant[0];
                    grant_n   = 2'b00;
                    state_n   = IDLE;
                end
`ifdef LINK_TIMEOUT_EN
                if (xfer) begin
                    idle_cnt_n = 8'd0;
                end else if (idle_cnt + 8'd1 == TIMEOUT) begin
                    // Abandon the stalled frame; its tail is flushed later as non-header words.
                    timeout_n  = 1'b1;
                    grant_n    = 2'b00;
                    prio_n     = ~prio;
                    state_n    = IDLE;
                    idle_cnt_n = 8'd0;
                end else begin
                    idle_cnt_n = idle_cnt + 8'd1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= 2'b00;
            start    <= 1'b0;
            prio     <= 1'b0;
            evt_cnt  <= 3'd0;
            last_bx  <= 8'd0;
            drop_cnt <= 8'd0;
`ifdef LINK_TIMEOUT_EN
            idle_cnt  <= 8'd0;
            timeout_q <= 1'b0;
`endif
        end else if (!en_proc) begin
            state <= IDLE;
            grant <= 2'b00;
            start <= 1'b0;
`ifdef LINK_TIMEOUT_EN
            idle_cnt <= 8'd0;
`endif
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            start    <= start_n;
            prio     <= prio_n;
            evt_cnt  <= evt_cnt_n;
            last_bx  <= last_bx_n;
            drop_cnt <= drop_cnt_n;
`ifdef LINK_TIMEOUT_EN
            idle_cnt  <= idle_cnt_n;
            timeout_q <= timeout_n;
`endif
        end
    end
endmodule

// File: doc/link_event_arbiter.md
# link_event_arbiter

Shares one `DiskLayerRouter` stub input between two input link FIFOs (first-word-fall-through) carrying framed events. A frame is a header word, a counts word, stub words and a trailer word. The block grants one link per event in round-robin order and issues the router's `start` pulse. It then streams that link's frame word-by-word under the router's `read_en` and releases the grant on the trailer. It sits between the link input memories and the layer router in the sector processing chain.

## Interface
Parameters:
- `TIMEOUT`, 8'd80, idle cycles within a granted frame before abort (used only when the timeout feature is compiled in).

Ports:
- `clk`  in  1  processing clock
- `reset`  in  1  synchronous, active-low reset
- `en_proc`  in  1  processing enable; low forces IDLE
- `link0_data`  in  36  head word of link 0 FIFO
- `link0_empty`  in  1  link 0 FIFO empty
- `link0_rd_en`  out  1  pop link 0
- `link1_data`  in  36  head word of link 1 FIFO
- `link1_empty`  in  1  link 1 FIFO empty
- `link1_rd_en`  out  1  pop link 1
- `router_rd_en`  in  1  router `read_en`; a word transfers when `stub_valid & router_rd_en`
- `start`  out  1  one-cycle event start to router
- `stub_out`  out  36  granted link head word (combinational mux)
- `stub_valid`  out  1  granted link non-empty while in XFER
- `grant`  out  2  one-hot grant; 2'b00 when none
- `evt_cnt`  out  3  completed events mod 8
- `last_bx`  out  8  BX field [32:25] of last forwarded trailer
- `drop_cnt`  out  8  saturating count of discarded non-header words
- `timeout_err`  out  1  sticky frame-abort flag

## Operation
- Header word: [35:33]=3'b111 and [24:0]=25'h1ffffff. Trailer word: [35:33]=3'b111 and [24:0]=25'h0.
- States:
  - IDLE:
    - Candidate link = non-empty with header at head.
    - Both candidates: the `prio` link wins; `prio` resets to link 0.
    - Any non-empty link whose head is not a header, and is not being granted this cycle, is popped; `drop_cnt` increments (saturates at 255).
    - On a winner, latch `grant` and go to START.
  - START: `start`=1 for exactly this cycle; no pops; next state XFER.
  - XFER:
    - `linkN_rd_en` = `grant[N] & ~linkN_empty & router_rd_en`; other link's rd_en=0.
    - Every word (header, counts, stubs, trailer) is forwarded unmodified.
    - On trailer transfer: `last_bx` <= word[32:25]; `evt_cnt` += 1 (wraps 7->0); `prio` <= other link; `grant` <= 0; go to IDLE.
- Reset (`reset`=0 at a clock edge) or `en_proc`=0:
  - state IDLE, `grant`=0, `start`=0.
  - Reset also clears `prio`, `evt_cnt`, `last_bx`, `drop_cnt`, `timeout_err`. `en_proc`=0 holds them.
- Reset mid-frame: the partially read frame remains in the FIFO. Its tail words are later discarded in IDLE as non-headers.
- All outputs except `stub_out`, `stub_valid` and `linkN_rd_en` are registered. Reset values: all zero; `stub_out` follows the mux (0 when `grant`=0).

## Timing
- Header at FIFO head in IDLE cycle n: `grant` valid n+1, `start`=1 in cycle n+1, XFER from n+2.
- Transfers occur combinationally in any XFER cycle with `router_rd_en` & non-empty, giving 1 word/cycle peak.
- Trailer transferred in cycle m: IDLE at m+1, earliest next `start` at m+2.
- Empty granted link in XFER: `stub_valid`=0, state holds (stall).

## Configuration
- `LINK_TIMEOUT_EN` defined:
  - A 8-bit counter clears on each transfer and on entry to XFER, and increments otherwise in XFER.
  - When it reaches `TIMEOUT`: `timeout_err` <= 1, `grant` <= 0, `prio` toggles, go to IDLE, `evt_cnt` unchanged.
- Not defined: no counter; XFER waits indefinitely; `timeout_err` tied 0.

## Test plan
- Link0 frame {header, counts 0x041041041, 4 stubs, trailer BX=0x05}, `router_rd_en`=1 -> `start` one cycle after header seen; 7 words forwarded in order; `last_bx`=0x05, `evt_cnt`=1, `grant`=0.
- Headers on both links simultaneously after reset -> link0 granted first; after its trailer, link1 granted; a third pair -> link0 again.
- Link1 head holds 3 non-header words, link0 empty -> 3 pops, `drop_cnt`=3, no `start`.
- `router_rd_en` toggled every other cycle mid-frame -> pops only when high; word order intact; no duplicates.
- `reset`=0 during XFER on word 3 of 7 -> next cycle IDLE, all counters 0; remaining 4 words dropped, `drop_cnt`=4.
- With `LINK_TIMEOUT_EN`, `TIMEOUT`=8, link0 empties after counts word -> `timeout_err`=1 eight cycles after last transfer, grant released, `evt_cnt` unchanged.
